// File: rtl/des_pkg.sv
// Shared definitions for the DES campaign controller: FSM state encoding,
// default widths and the default gap between regions.
package des_pkg;

    localparam int DEF_REGION_W   = 16;
    localparam int DEF_COUNT_W    = 48;
    localparam int DEF_TOTAL_W    = 64;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_TIMEOUT_W  = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RELEASE = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/sat_accumulator.sv
// Saturating accumulator: adds a zero-extended IN_W operand into an OUT_W
// running sum that sticks at all-ones instead of wrapping.
module sat_accumulator #(
    parameter int IN_W  = 48,
    parameter int OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_add_en,
    input  logic [IN_W-1:0]  i_add_val,
    output logic [OUT_W-1:0] o_sum
);

    logic [OUT_W-1:0] r_sum;
    logic [OUT_W:0]   w_sum_ext;

    // One extra bit catches the carry that signals overflow.
    assign w_sum_ext = {1'b0, r_sum} + (OUT_W+1)'(i_add_val);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_sum <= '0;
        end else if (i_add_en) begin
            r_sum <= w_sum_ext[OUT_W] ? '1 : w_sum_ext[OUT_W-1:0];
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/des_campaign_ctrl.sv
// Sequences a DES cracking block over a (possibly wrapping) range of regions
// and sums the per-region hit counts. Define DES_CAMPAIGN_LOG_EN for log outputs.
module des_campaign_ctrl
    import des_pkg::*;
#(
    parameter int REGION_W   = DEF_REGION_W,
    parameter int COUNT_W    = DEF_COUNT_W,
    parameter int TOTAL_W    = DEF_TOTAL_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT_W  = DEF_TIMEOUT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic                abort,
    input  logic [REGION_W-1:0] region_first,
    input  logic [REGION_W-1:0] region_last,
    output logic                blk_start,
    output logic [REGION_W-1:0] blk_region_select,
    input  logic [COUNT_W-1:0]  blk_counter,
    input  logic                blk_valid,
    output logic [TOTAL_W-1:0]  total_count,
    output logic [REGION_W:0]   regions_done,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                timeout
`ifdef DES_CAMPAIGN_LOG_EN
    ,
    output logic                log_valid,
    output logic [REGION_W-1:0] log_region,
    output logic [COUNT_W-1:0]  log_count
`endif
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [REGION_W-1:0] r_cur_region;
    logic [REGION_W-1:0] r_last_region;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic [TIMEOUT_W-1:0] w_wdog_inc;
    logic [GAP_W-1:0]    r_gap;
    logic [REGION_W:0]   r_regions_done;
    logic                r_aborted;
    logic                r_timeout;
    logic                w_go_accept;
    logic                w_timeout_hit;
    logic                w_abort_req;
    logic                w_gap_end;
    logic                w_busy;

    assign w_wdog_inc  = r_wdog + TIMEOUT_W'(1);
    assign w_abort_req = abort || r_aborted;
    assign w_gap_end   = (r_gap == GAP_W'(GAP_CYCLES - 1));
    assign w_busy      = (r_state != IDLE) && (r_state != DONE);

    always_comb begin
        w_state_next  = r_state;
        w_go_accept   = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (go) begin
                    w_go_accept  = 1'b1;
                    w_state_next = LAUNCH;
                end
            end
            LAUNCH:  w_state_next = WAIT;
            WAIT: begin
                // Abort wins over a same-cycle result, which wins over the watchdog.
                if (w_abort_req) begin
                    w_state_next = RELEASE;
                end else if (blk_valid) begin
                    w_state_next = CAPTURE;
                end else if (w_wdog_inc == '1) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = RELEASE;
                end
            end
            CAPTURE: w_state_next = RELEASE;
            RELEASE: begin
                if (w_gap_end) begin
                    w_state_next = (w_abort_req || r_timeout || (r_cur_region == r_last_region))
                                   ? DONE : LAUNCH;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cur_region   <= '0;
            r_last_region  <= '0;
            r_wdog         <= '0;
            r_gap          <= '0;
            r_regions_done <= '0;
            r_aborted      <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_go_accept) begin
                r_cur_region   <= region_first;
                r_last_region  <= region_last;
                r_regions_done <= '0;
                r_aborted      <= 1'b0;
                r_timeout      <= 1'b0;
            end
            // Sticky, so an abort seen in LAUNCH or CAPTURE still ends the run in RELEASE.
            if (w_busy && abort) begin
                r_aborted <= 1'b1;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            case (r_state)
                LAUNCH:  r_wdog <= '0;
                WAIT:    r_wdog <= w_wdog_inc;
                CAPTURE: r_regions_done <= r_regions_done + (REGION_W+1)'(1);
                RELEASE: begin
                    r_gap <= w_gap_end ? '0 : r_gap + GAP_W'(1);
                    if (w_state_next == LAUNCH) begin
                        r_cur_region <= r_cur_region + REGION_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    sat_accumulator #(
        .IN_W  (COUNT_W),
        .OUT_W (TOTAL_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_go_accept),
        .i_add_en  (r_state == CAPTURE),
        .i_add_val (blk_counter),
        .o_sum     (total_count)
    );

    // Gated by rst_n so the block sees start fall in the very cycle reset is applied.
    assign blk_start = rst_n && ((r_state == LAUNCH) || (r_state == WAIT) || (r_state == CAPTURE));
    assign blk_region_select = r_cur_region;
    assign regions_done      = r_regions_done;
    assign busy              = w_busy;
    assign done              = (r_state == DONE);
    assign aborted           = r_aborted;
    assign timeout           = r_timeout;

`ifdef DES_CAMPAIGN_LOG_EN
    logic [COUNT_W-1:0] r_log_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_log_count <= '0;
        end else if ((r_state == WAIT) && blk_valid) begin
            r_log_count <= blk_counter;
        end
    end

    assign log_valid  = (r_state == CAPTURE);
    assign log_region = r_cur_region;
    assign log_count  = r_log_count;
`endif

endmodule

// File: tb/tb_des_campaign_ctrl.sv
// Self-checking bench for des_campaign_ctrl: a behavioural DES block model plus
// a reference that computes expected totals and region sequences arithmetically.
module tb_des_campaign_ctrl;

    localparam int RW = 16;
    localparam int CW = 48;
    localparam int TW = 50;
    localparam logic [63:0] SAT50 = (64'd1 << 50) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // main instance: TOTAL_W=50 so saturation is reachable
    logic          a_go, a_abort, a_start, a_valid;
    logic [RW-1:0] a_first, a_last, a_sel;
    logic [CW-1:0] a_counter;
    logic [TW-1:0] a_total;
    logic [RW:0]   a_rdone;
    logic          a_busy, a_done, a_aborted, a_timeout;

    // watchdog instance: TIMEOUT_W=4
    logic          t_go, t_abort, t_start, t_valid;
    logic [RW-1:0] t_first, t_last, t_sel;
    logic [CW-1:0] t_counter;
    logic [63:0]   t_total;
    logic [RW:0]   t_rdone;
    logic          t_busy, t_done, t_aborted, t_timeout;

`ifdef DES_CAMPAIGN_LOG_EN
    logic          a_log_valid, t_log_valid;
    logic [RW-1:0] a_log_region, t_log_region;
    logic [CW-1:0] a_log_count, t_log_count;
`endif

    des_campaign_ctrl #(
        .REGION_W(RW), .COUNT_W(CW), .TOTAL_W(TW), .GAP_CYCLES(2), .TIMEOUT_W(32)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .go(a_go), .abort(a_abort),
        .region_first(a_first), .region_last(a_last),
        .blk_start(a_start), .blk_region_select(a_sel),
        .blk_counter(a_counter), .blk_valid(a_valid),
        .total_count(a_total), .regions_done(a_rdone),
        .busy(a_busy), .done(a_done), .aborted(a_aborted), .timeout(a_timeout)
`ifdef DES_CAMPAIGN_LOG_EN
        , .log_valid(a_log_valid), .log_region(a_log_region), .log_count(a_log_count)
`endif
    );

    des_campaign_ctrl #(
        .REGION_W(RW), .COUNT_W(CW), .TOTAL_W(64), .GAP_CYCLES(2), .TIMEOUT_W(4)
    ) dut_t (
        .clk(clk), .rst_n(rst_n), .go(t_go), .abort(t_abort),
        .region_first(t_first), .region_last(t_last),
        .blk_start(t_start), .blk_region_select(t_sel),
        .blk_counter(t_counter), .blk_valid(t_valid),
        .total_count(t_total), .regions_done(t_rdone),
        .busy(t_busy), .done(t_done), .aborted(t_aborted), .timeout(t_timeout)
`ifdef DES_CAMPAIGN_LOG_EN
        , .log_valid(t_log_valid), .log_region(t_log_region), .log_count(t_log_count)
`endif
    );

    // DES block model: valid 'lat' cycles after start rises, held while start is high
    int            lat = 20;
    bit            junk_en = 1'b0;
    logic [CW-1:0] cnt_tab [0:15];
    int            launch_idx = 0;
    int            hi_cyc = 0;
    int            lo_cyc = 0;
    logic          prev_start = 1'b0;
    logic [RW-1:0] sel_log [$];
    int            gap_log [$];

    always @(negedge clk) begin
        if (a_start === 1'b1) begin
            if (!prev_start) begin
                sel_log.push_back(a_sel);
                if (launch_idx > 0) gap_log.push_back(lo_cyc);
                launch_idx = launch_idx + 1;
                hi_cyc = 0;
            end
            hi_cyc = hi_cyc + 1;
            if (hi_cyc >= lat) begin
                a_valid   = 1'b1;
                a_counter = cnt_tab[(launch_idx - 1) % 16];
            end else begin
                a_valid   = 1'b0;
                a_counter = CW'({$urandom, $urandom});
            end
            prev_start = 1'b1;
        end else begin
            lo_cyc = prev_start ? 1 : lo_cyc + 1;
            // stray valid while start is low must be ignored by the controller
            a_valid   = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            a_counter = CW'({$urandom, $urandom});
            prev_start = 1'b0;
        end
    end

    function automatic int exp_regions(input logic [RW-1:0] f, input logic [RW-1:0] l);
        logic [RW-1:0] d;
        d = l - f;
        return int'(d) + 1;
    endfunction

    function automatic logic [TW-1:0] exp_total(input int n);
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < n; i++) s = s + {16'd0, cnt_tab[i]};
        if (s > SAT50) s = SAT50;
        return s[TW-1:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [RW-1:0] f, input logic [RW-1:0] l);
        launch_idx = 0;
        sel_log.delete();
        gap_log.delete();
        a_first = f;
        a_last  = l;
        a_go    = 1'b1;
        tick();
        a_go    = 1'b0;
    endtask

    task automatic wait_done_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (a_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (a_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", a_start); end
        checks++; if (a_sel !== '0) begin errors++; $display("FAIL reset_sel: got %h want 0", a_sel); end
        checks++; if (a_total !== '0) begin errors++; $display("FAIL reset_total: got %h want 0", a_total); end
        checks++; if (a_rdone !== '0) begin errors++; $display("FAIL reset_rdone: got %0d want 0", a_rdone); end
        checks++; if ({a_busy, a_done, a_aborted, a_timeout} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {a_busy, a_done, a_aborted, a_timeout});
        end
        rst_n = 1'b1;
        tick();
        $display("reset: start=%b total=%h rdone=%0d", a_start, a_total, a_rdone);
    endtask

    task automatic test_basic;
        bit ok;
        lat = 20; junk_en = 1'b0;
        cnt_tab[0] = 48'd10; cnt_tab[1] = 48'd20; cnt_tab[2] = 48'd30;
        start_a(16'd5, 16'd7);
        wait_done_a(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done: got done=%b want 1", a_done); end
        checks++; if (a_total !== 50'd60) begin errors++; $display("FAIL basic_total: got %0d want 60", a_total); end
        checks++; if (a_rdone !== 17'd3) begin errors++; $display("FAIL basic_rdone: got %0d want 3", a_rdone); end
        checks++; if (gap_log.size() != 2) begin errors++; $display("FAIL basic_gapcount: got %0d want 2", gap_log.size()); end
        foreach (gap_log[i]) begin
            checks++; if (gap_log[i] != 2) begin errors++; $display("FAIL basic_gap%0d: got %0d want 2", i, gap_log[i]); end
        end
        foreach (sel_log[i]) begin
            checks++; if (sel_log[i] !== 16'(5 + i)) begin
                errors++; $display("FAIL basic_sel%0d: got %h want %h", i, sel_log[i], 16'(5 + i));
            end
        end
        $display("basic: first=5 last=7 total=%0d rdone=%0d", a_total, a_rdone);
    endtask

    task automatic test_wrap;
        bit ok;
        logic [RW-1:0] want [4];
        want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000; want[3] = 16'h0001;
        lat = $urandom_range(1, 10); junk_en = 1'b1;
        for (int i = 0; i < 4; i++) cnt_tab[i] = CW'($urandom_range(0, 100000));
        start_a(16'hFFFE, 16'h0001);
        wait_done_a(ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_done: got done=%b want 1", a_done); end
        checks++; if (a_rdone !== 17'd4) begin errors++; $display("FAIL wrap_rdone: got %0d want 4", a_rdone); end
        checks++; if (sel_log.size() != 4) begin errors++; $display("FAIL wrap_launches: got %0d want 4", sel_log.size()); end
        for (int i = 0; i < 4 && i < sel_log.size(); i++) begin
            checks++; if (sel_log[i] !== want[i]) begin
                errors++; $display("FAIL wrap_sel%0d: got %h want %h", i, sel_log[i], want[i]);
            end
        end
        checks++; if (a_total !== exp_total(4)) begin
            errors++; $display("FAIL wrap_total: got %h want %h", a_total, exp_total(4));
        end
        $display("wrap: first=FFFE last=0001 rdone=%0d total=%0d", a_rdone, a_total);
    endtask

    task automatic test_saturation;
        bit ok;
        lat = 3; junk_en = 1'b0;
        for (int i = 0; i < 6; i++) cnt_tab[i] = '1;
        start_a(16'd0, 16'd5);
        wait_done_a(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_done: got done=%b want 1", a_done); end
        checks++; if (a_total !== SAT50[TW-1:0]) begin
            errors++; $display("FAIL sat_total: got %h want %h", a_total, SAT50[TW-1:0]);
        end
        checks++; if (a_rdone !== 17'd6) begin errors++; $display("FAIL sat_rdone: got %0d want 6", a_rdone); end
        $display("saturation: total=%h rdone=%0d", a_total, a_rdone);
    endtask

    task automatic test_random;
        bit ok;
        logic [RW-1:0] f, l;
        int n, en;
        for (int k = 0; k < 6; k++) begin
            f = RW'($urandom);
            n = $urandom_range(1, 8);
            l = f + RW'(n - 1);
            lat = $urandom_range(1, 25);
            junk_en = 1'b1;
            for (int i = 0; i < 16; i++)
                cnt_tab[i] = (k % 2 == 0) ? CW'({$urandom, $urandom}) : CW'($urandom_range(0, 5000));
            start_a(f, l);
            tick(); tick();
            // go while busy with different bounds must be ignored
            a_first = ~f; a_last = f; a_go = 1'b1;
            tick();
            a_go = 1'b0;
            wait_done_a(ok);
            en = exp_regions(f, l);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done: got done=%b want 1", k, a_done); end
            checks++; if (a_rdone !== 17'(en)) begin errors++; $display("FAIL rand%0d_rdone: got %0d want %0d", k, a_rdone, en); end
            checks++; if (a_total !== exp_total(en)) begin
                errors++; $display("FAIL rand%0d_total: got %h want %h", k, a_total, exp_total(en));
            end
            checks++; if (sel_log.size() != en) begin errors++; $display("FAIL rand%0d_launches: got %0d want %0d", k, sel_log.size(), en); end
            foreach (sel_log[i]) begin
                checks++; if (sel_log[i] !== f + RW'(i)) begin
                    errors++; $display("FAIL rand%0d_sel%0d: got %h want %h", k, i, sel_log[i], f + RW'(i));
                end
            end
            checks++; if ({a_aborted, a_timeout} !== 2'b00) begin
                errors++; $display("FAIL rand%0d_flags: got %b want 00", k, {a_aborted, a_timeout});
            end
            $display("random %0d: first=%h last=%h lat=%0d rdone=%0d total=%h", k, f, l, lat, a_rdone, a_total);
        end
    endtask

    task automatic test_abort;
        bit ok;
        bit reached;
        lat = 20; junk_en = 1'b0;
        for (int i = 0; i < 4; i++) cnt_tab[i] = CW'($urandom_range(1, 1000000));
        start_a(16'd10, 16'd13);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (launch_idx >= 2) begin reached = 1'b1; break; end
            tick();
        end
        checks++; if (!reached) begin errors++; $display("FAIL abort_second_launch: got %0d launches want 2", launch_idx); end
        repeat (4) tick();
        a_abort = 1'b1;
        tick();
        checks++; if (a_start !== 1'b0) begin errors++; $display("FAIL abort_start_drop: got %b want 0", a_start); end
        a_abort = 1'b0;
        wait_done_a(ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_done: got done=%b want 1", a_done); end
        checks++; if (a_aborted !== 1'b1) begin errors++; $display("FAIL abort_flag: got %b want 1", a_aborted); end
        checks++; if (a_rdone !== 17'd1) begin errors++; $display("FAIL abort_rdone: got %0d want 1", a_rdone); end
        checks++; if (a_total !== exp_total(1)) begin
            errors++; $display("FAIL abort_total: got %h want %h", a_total, exp_total(1));
        end
        checks++; if (a_timeout !== 1'b0) begin errors++; $display("FAIL abort_timeout: got %b want 0", a_timeout); end
        $display("abort: aborted=%b rdone=%0d total=%h", a_aborted, a_rdone, a_total);
    endtask

    task automatic test_timeout;
        int hi;
        bit ok;
        t_first = 16'd3; t_last = 16'd3; t_go = 1'b1;
        tick();
        t_go = 1'b0;
        hi = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (t_done) begin ok = 1'b1; break; end
            if (t_start) hi++;
            tick();
        end
        checks++; if (!ok) begin errors++; $display("FAIL timeout_done: got done=%b want 1", t_done); end
        checks++; if (hi != 16) begin errors++; $display("FAIL timeout_start_cycles: got %0d want 16", hi); end
        checks++; if (t_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", t_timeout); end
        checks++; if (t_rdone !== '0) begin errors++; $display("FAIL timeout_rdone: got %0d want 0", t_rdone); end
        checks++; if (t_total !== 64'd0) begin errors++; $display("FAIL timeout_total: got %h want 0", t_total); end
        $display("timeout: start_cycles=%0d timeout=%b done=%b", hi, t_timeout, t_done);
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit reached;
        lat = 20; junk_en = 1'b0;
        for (int i = 0; i < 3; i++) cnt_tab[i] = CW'($urandom_range(1, 1000000));
        start_a(16'd100, 16'd102);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (launch_idx >= 2) begin reached = 1'b1; break; end
            tick();
        end
        checks++; if (!reached) begin errors++; $display("FAIL rstmid_second_launch: got %0d launches want 2", launch_idx); end
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checks++; if (a_start !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %b want 0", a_start); end
        checks++; if (a_sel !== '0) begin errors++; $display("FAIL rstmid_sel: got %h want 0", a_sel); end
        checks++; if (a_total !== '0) begin errors++; $display("FAIL rstmid_total: got %h want 0", a_total); end
        checks++; if (a_rdone !== '0) begin errors++; $display("FAIL rstmid_rdone: got %0d want 0", a_rdone); end
        checks++; if ({a_busy, a_done, a_aborted, a_timeout} !== 4'b0) begin
            errors++; $display("FAIL rstmid_flags: got %b want 0000", {a_busy, a_done, a_aborted, a_timeout});
        end
        rst_n = 1'b1;
        tick();
        start_a(16'd100, 16'd102);
        wait_done_a(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_restart_done: got done=%b want 1", a_done); end
        checks++; if (a_rdone !== 17'd3) begin errors++; $display("FAIL rstmid_restart_rdone: got %0d want 3", a_rdone); end
        checks++; if (a_total !== exp_total(3)) begin
            errors++; $display("FAIL rstmid_restart_total: got %h want %h", a_total, exp_total(3));
        end
        $display("reset mid-wait: restart rdone=%0d total=%h", a_rdone, a_total);
    endtask

    initial begin
        rst_n = 1'b0;
        a_go = 1'b0; a_abort = 1'b0; a_first = '0; a_last = '0;
        a_valid = 1'b0; a_counter = '0;
        t_go = 1'b0; t_abort = 1'b0; t_first = '0; t_last = '0;
        t_valid = 1'b0; t_counter = '0;
        for (int i = 0; i < 16; i++) cnt_tab[i] = '0;

        test_reset();
        test_basic();
        test_wrap();
        test_saturation();
        test_random();
        test_abort();
        test_timeout();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_campaign_ctrl.md
DES_CAMPAIGN_CTRL -- requirements
Module: des_campaign_ctrl

Interface
REQ-001 SHALL have parameter REGION_W, default 16: width of the region index.
REQ-002 SHALL have parameter COUNT_W, default 48: width of the per-block hit counter.
REQ-003 SHALL have parameter TOTAL_W, default 64: width of the campaign accumulator.
REQ-004 SHALL have parameter GAP_CYCLES, default 2: minimum number of low cycles on blk_start between regions.
REQ-005 SHALL have parameter TIMEOUT_W, default 32: width of the per-region watchdog.
REQ-006 clk  in  1  clock; all logic is on the rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 go  in  1  single-cycle campaign request; sampled only in IDLE.
REQ-009 abort  in  1  level; requests early termination.
REQ-010 region_first  in  REGION_W  first region; sampled on an accepted go.
REQ-011 region_last  in  REGION_W  last region, inclusive; sampled on an accepted go.
REQ-012 blk_start  out  1  start level to the DES cracking block.
REQ-013 blk_region_select  out  REGION_W  region driven to the block.
REQ-014 blk_counter  in  COUNT_W  block hit count; meaningful only while blk_valid=1.
REQ-015 blk_valid  in  1  block result valid; held while blk_start=1.
REQ-016 total_count  out  TOTAL_W  saturating sum of the captured counts.
REQ-017 regions_done  out  REGION_W+1  number of regions captured.
REQ-018 busy / done / aborted / timeout  out  1 each  status flags.

Function
REQ-019 FSM states SHALL be: IDLE, LAUNCH, WAIT, CAPTURE, RELEASE, DONE.
REQ-020 IDLE + go SHALL latch the region bounds, clear total_count, regions_done and all status flags, load cur_region=region_first, and go to LAUNCH.
REQ-021 LAUNCH SHALL drive blk_start=1 and blk_region_select=cur_region, clear the watchdog, and go to WAIT.
REQ-022 WAIT SHALL hold blk_start=1, increment the watchdog, and go to CAPTURE on blk_valid=1.
REQ-023 CAPTURE SHALL add blk_counter, zero-extended, to total_count in the same edge while blk_start is still 1, and increment regions_done; the capture latency is one cycle from blk_valid.
REQ-024 Accumulation SHALL saturate at all-ones; there is no wrap.
REQ-025 RELEASE SHALL drive blk_start=0 for exactly GAP_CYCLES cycles, then:
  - go to DONE if the last region was captured, or on abort or timeout;
  - otherwise set cur_region=cur_region+1, modulo 2^REGION_W, and go to LAUNCH.
REQ-026 Region ordering SHALL wrap: when region_last < region_first, the sequence is first..max, 0..last. The region total is ((last-first) mod 2^REGION_W)+1, up to 2^REGION_W.
REQ-027 abort during WAIT SHALL go directly to RELEASE, discard the in-flight count, and set aborted.
REQ-028 abort during LAUNCH or CAPTURE SHALL complete that state and then be honoured in RELEASE.
REQ-029 If the watchdog reaches all-ones in WAIT, the block SHALL set timeout and go to RELEASE without capturing.
REQ-030 DONE SHALL assert done=1 and hold all results until the next accepted go, then behave as IDLE; go has priority over hold.
REQ-031 busy SHALL be 1 in every state except IDLE and DONE, and go while busy SHALL be ignored.
REQ-032 blk_valid outside WAIT SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL force IDLE, blk_start=0, blk_region_select=0, total_count=0, regions_done=0, and busy, done, aborted and timeout all 0.
REQ-034 Reset mid-campaign SHALL drop blk_start in the same cycle, so the block clears its own counter.

Configuration
REQ-035 DES_CAMPAIGN_LOG_EN defined SHALL add these outputs:
  - log_valid: a one-cycle pulse in CAPTURE;
  - log_region (REGION_W);
  - log_count (COUNT_W), carrying the raw per-region count.
REQ-036 DES_CAMPAIGN_LOG_EN undefined SHALL leave these ports and their registers absent; all other behaviour is identical.

Structure
REQ-037 State encoding, default widths and the GAP_CYCLES default SHALL live in the shared package des_pkg.
REQ-038 The saturating accumulator SHALL be the sub-module sat_accumulator, with parameterised input and output widths.

Verification
REQ-039 first=5, last=7, block model valid after 20 cycles with counts 10/20/30: total_count=60, regions_done=3, done=1, and blk_start low for 2 cycles between regions.
REQ-040 first=0xFFFE, last=0x0001: blk_region_select sequence FFFE, FFFF, 0000, 0001, with regions_done=4.
REQ-041 Counts all-ones on TOTAL_W=50: total_count saturates at 2^50-1 with no wrap.
REQ-042 abort raised in WAIT of the 2nd region: aborted=1, regions_done=1, total excludes region 2, and blk_start=0 within 1 cycle.
REQ-043 TIMEOUT_W=4 with blk_valid never asserted: timeout=1 after 15 WAIT cycles, done=1, regions_done=0.
REQ-044 rst_n low mid-WAIT: next cycle all outputs are at reset values; a subsequent go restarts cleanly.
